// File: rtl/updi_pkg.sv
// Shared types for the UPDI transaction controller: interface instruction set,
// request opcodes, response error codes and the controller FSM state.
package updi_pkg;

  typedef enum logic [2:0] {
    UPDI_LDS    = 3'd0,
    UPDI_STS    = 3'd1,
    UPDI_LD     = 3'd2,
    UPDI_ST     = 3'd3,
    UPDI_LDCS   = 3'd4,
    UPDI_STCS   = 3'd5,
    UPDI_REPEAT = 3'd6,
    UPDI_KEY    = 3'd7
  } updi_instruction;

  typedef enum logic [1:0] {
    OP_LDCS = 2'd0,
    OP_STCS = 2'd1,
    OP_LDS  = 2'd2,
    OP_STS  = 2'd3
  } updi_txn_op_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ACK_ERR = 2'd1,
    ERR_TIMEOUT = 2'd2
  } updi_txn_err_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_TX_START,
    ST_TX_WAIT,
    ST_RX_START,
    ST_RX_WAIT,
    ST_POP,
    ST_RESP,
    ST_RETRY_GAP
  } updi_txn_state_t;

  function automatic logic is_load(updi_txn_op_t op);
    return (op == OP_LDCS) || (op == OP_LDS);
  endfunction

endpackage

// File: rtl/updi_txn_watchdog.sv
// Per-phase watchdog: counts while enabled, clears on demand, flags when the
// count reaches LIMIT-1 and then holds there.
module updi_txn_watchdog #(
  parameter int LIMIT = 100000,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          expired
);

  logic [CW-1:0] count_q, count_d;

  assign expired = (count_q == CW'(LIMIT - 1));
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (clr)                 count_d = '0;
    else if (en && !expired) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/updi_txn_controller.sv
// Runs one LDCS/STCS/LDS/STS transaction at a time on the UPDI interface.
// Define UPDI_TXN_RETRY_EN to retry failed transactions up to two extra times.
module updi_txn_controller
  import updi_pkg::*;
#(
  parameter int MAX_DATA_SIZE  = 16,
  parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [1:0]                         req_op,
  input  logic [15:0]                        req_addr,
  input  logic [7:0]                         req_wdata,
  output logic                               rsp_valid,
  output logic [7:0]                         rsp_rdata,
  output logic [1:0]                         rsp_err,
  output logic                               instr_converter_en,
  output updi_instruction                    instruction,
  output logic [1:0]                         size_a,
  output logic [1:0]                         size_b,
  output logic [1:0]                         ptr,
  output logic [1:0]                         size_c,
  output logic [3:0]                         cs_addr,
  output logic                               sib,
  output logic [MAX_DATA_SIZE-1:0][7:0]      data,
  output logic [DATA_ADDR_BITS:0]            data_len,
  output logic [MAX_DATA_SIZE-1:0]           wait_ack_after,
  output logic                               tx_start,
  input  logic                               tx_ready,
  output logic [DATA_ADDR_BITS-1:0]          rx_n_bytes,
  output logic                               rx_start,
  input  logic                               rx_ready,
  input  logic                               rx_done,
  input  logic                               rx_timeout,
  input  logic                               ack_error,
  input  logic [7:0]                         rx_fifo_data,
  input  logic                               rx_fifo_empty,
  output logic                               rx_fifo_rd_en
);

  localparam int LW   = DATA_ADDR_BITS + 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  updi_txn_state_t                  state_q, state_d;
  updi_txn_op_t                     op_q, op_d;
  logic [1:0]                       retry_cnt_q, retry_cnt_d;
  logic                             req_ready_q, req_ready_d;
  logic                             rsp_valid_q, rsp_valid_d;
  logic [7:0]                       rsp_rdata_q, rsp_rdata_d;
  updi_txn_err_t                    rsp_err_q, rsp_err_d;
  logic                             instr_en_q, instr_en_d;
  updi_instruction                  instruction_q, instruction_d;
  logic [1:0]                       size_a_q, size_a_d;
  logic [3:0]                       cs_addr_q, cs_addr_d;
  logic [MAX_DATA_SIZE-1:0][7:0]    data_q, data_d;
  logic [LW-1:0]                    data_len_q, data_len_d;
  logic [MAX_DATA_SIZE-1:0]         mask_q, mask_d;
  logic [DATA_ADDR_BITS-1:0]        rx_n_bytes_q, rx_n_bytes_d;
  logic                             tx_start_q, tx_start_d;
  logic                             rx_start_q, rx_start_d;
  logic                             rd_en_q, rd_en_d;

  logic            accept, watched, err_hit, wd_expired;
  updi_txn_err_t   err_code;
  logic [WD_W-1:0] wd_count;

  assign accept  = req_valid && req_ready_q;
  assign watched = (state_q == ST_TX_START) || (state_q == ST_TX_WAIT) ||
                   (state_q == ST_RX_START) || (state_q == ST_RX_WAIT) ||
                   (state_q == ST_POP);

  updi_txn_watchdog #(.LIMIT(TIMEOUT_CYCLES), .CW(WD_W)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_d != state_q),
    .en      (watched || (state_q == ST_RETRY_GAP)),
    .count   (wd_count),
    .expired (wd_expired)
  );

  // NOTE: every _d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    retry_cnt_d   = retry_cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    instruction_d = instruction_q;
    size_a_d      = size_a_q;
    cs_addr_d     = cs_addr_q;
    data_d        = data_q;
    data_len_d    = data_len_q;
    mask_d        = mask_q;
    rx_n_bytes_d  = rx_n_bytes_q;
    tx_start_d    = 1'b0;
    rx_start_d    = 1'b0;
    rd_en_d       = 1'b0;
    err_hit       = 1'b0;
    err_code      = ERR_OK;

    case (state_q)
      ST_IDLE: if (accept) begin
        // The whole interface setup is derived here and held across retries.
        op_d          = updi_txn_op_t'(req_op);
        retry_cnt_d   = 2'd0;
        size_a_d      = 2'd0;
        cs_addr_d     = 4'd0;
        data_d        = '0;
        data_len_d    = '0;
        mask_d        = '0;
        rx_n_bytes_d  = '0;
        state_d       = ST_SETUP;
        case (updi_txn_op_t'(req_op))
          OP_LDCS: begin
            instruction_d = UPDI_LDCS;
            cs_addr_d     = req_addr[3:0];
            rx_n_bytes_d  = DATA_ADDR_BITS'(1);
          end
          OP_STCS: begin
            instruction_d = UPDI_STCS;
            cs_addr_d     = req_addr[3:0];
            data_d[0]     = req_wdata;
            data_len_d    = LW'(1);
          end
          OP_LDS: begin
            instruction_d = UPDI_LDS;
            size_a_d      = 2'd1;
            data_d[0]     = req_addr[7:0];
            data_d[1]     = req_addr[15:8];
            data_len_d    = LW'(2);
            rx_n_bytes_d  = DATA_ADDR_BITS'(1);
          end
          default: begin
            instruction_d = UPDI_STS;
            size_a_d      = 2'd1;
            data_d[0]     = req_addr[7:0];
            data_d[1]     = req_addr[15:8];
            data_d[2]     = req_wdata;
            data_len_d    = LW'(3);
            mask_d        = MAX_DATA_SIZE'(3'b110);
          end
        endcase
      end
      ST_SETUP: state_d = ST_TX_START;
      ST_TX_START: if (tx_ready) begin
        tx_start_d = 1'b1;
        rx_start_d = |mask_q;
        state_d    = ST_TX_WAIT;
      end
      ST_TX_WAIT: if (tx_ready && !tx_start_q) begin
        if (is_load(op_q))  state_d = ST_RX_START;
        else if (|mask_q)   state_d = ST_RX_WAIT;
        else begin
          state_d     = ST_RESP;
          rsp_err_d   = ERR_OK;
          rsp_rdata_d = 8'h00;
        end
      end
      ST_RX_START: if (rx_ready) begin
        rx_start_d = 1'b1;
        state_d    = ST_RX_WAIT;
      end
      ST_RX_WAIT: if (!rx_start_q) begin
        if (ack_error) begin
          err_hit  = 1'b1;
          err_code = ERR_ACK_ERR;
        end else if (rx_timeout) begin
          err_hit  = 1'b1;
          err_code = ERR_TIMEOUT;
        end else if (rx_done) begin
          if (is_load(op_q)) state_d = ST_POP;
          else begin
            state_d     = ST_RESP;
            rsp_err_d   = ERR_OK;
            rsp_rdata_d = 8'h00;
          end
        end
      end
      ST_POP: if (!rx_fifo_empty) begin
        rd_en_d     = 1'b1;
        rsp_rdata_d = rx_fifo_data;
        rsp_err_d   = ERR_OK;
        state_d     = ST_RESP;
      end
      ST_RESP:      state_d = ST_IDLE;
      ST_RETRY_GAP: if (wd_count == WD_W'(2)) state_d = ST_SETUP;
      default:      state_d = ST_IDLE;
    endcase

    if (watched && wd_expired) begin
      err_hit    = 1'b1;
      err_code   = ERR_TIMEOUT;
      tx_start_d = 1'b0;
      rx_start_d = 1'b0;
      rd_en_d    = 1'b0;
    end

    if (err_hit) begin
`ifdef UPDI_TXN_RETRY_EN
      if (retry_cnt_q != 2'd2) begin
        retry_cnt_d = retry_cnt_q + 2'd1;
        state_d     = ST_RETRY_GAP;
      end else begin
        state_d     = ST_RESP;
        rsp_err_d   = err_code;
        rsp_rdata_d = 8'h00;
      end
`else
      state_d     = ST_RESP;
      rsp_err_d   = err_code;
      rsp_rdata_d = 8'h00;
`endif
    end

    rsp_valid_d = (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
    instr_en_d  = (state_d == ST_SETUP) || (state_d == ST_TX_START) ||
                  (state_d == ST_TX_WAIT);
  end

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_LDCS;
      retry_cnt_q   <= 2'd0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      rsp_err_q     <= ERR_OK;
      instr_en_q    <= 1'b0;
      instruction_q <= UPDI_LDS;
      size_a_q      <= 2'd0;
      cs_addr_q     <= 4'd0;
      // NOTE: the TX buffer is a handful of flops driving ports, so it is reset
      // like any other output rather than treated as an uninitialised RAM.
      data_q        <= '0;
      data_len_q    <= '0;
      mask_q        <= '0;
      rx_n_bytes_q  <= '0;
      tx_start_q    <= 1'b0;
      rx_start_q    <= 1'b0;
      rd_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      retry_cnt_q   <= retry_cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      instr_en_q    <= instr_en_d;
      instruction_q <= instruction_d;
      size_a_q      <= size_a_d;
      cs_addr_q     <= cs_addr_d;
      data_q        <= data_d;
      data_len_q    <= data_len_d;
      mask_q        <= mask_d;
      rx_n_bytes_q  <= rx_n_bytes_d;
      tx_start_q    <= tx_start_d;
      rx_start_q    <= rx_start_d;
      rd_en_q       <= rd_en_d;
    end
  end

  assign req_ready          = req_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_err            = rsp_err_q;
  assign instr_converter_en = instr_en_q;
  assign instruction        = instruction_q;
  assign size_a             = size_a_q;
  assign size_b             = 2'd0;
  assign ptr                = 2'd0;
  assign size_c             = 2'd0;
  assign sib                = 1'b0;
  assign cs_addr            = cs_addr_q;
  assign data               = data_q;
  assign data_len           = data_len_q;
  assign wait_ack_after     = mask_q;
  assign rx_n_bytes         = rx_n_bytes_q;
  assign tx_start           = tx_start_q;
  assign rx_start           = rx_start_q;
  assign rx_fifo_rd_en      = rd_en_q;

endmodule

// File: doc/updi_txn_controller.md
Name: updi_txn_controller

Overview:
- Sequences single UPDI transactions (LDCS, STCS, LDS, STS) on the UPDI interface bridge on behalf of one requester.
- Per request: configures the instruction converter, fills the TX data buffer and ACK mask, starts TX, arms RX, then collects the result from the output RX data FIFO.
- Sits between the host command layer and the UPDI interface. It is the only driver of that interface's instruction, TX and RX control inputs.

Parameters:
- MAX_DATA_SIZE, 16, TX buffer depth; must match the UPDI interface.
- DATA_ADDR_BITS, $clog2(MAX_DATA_SIZE), buffer index width.
- TIMEOUT_CYCLES, 100000, watchdog limit per transaction phase.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, can accept a request
- req_op  in  2  0=LDCS 1=STCS 2=LDS 3=STS
- req_addr  in  16  CS address (bits[3:0]) or data-space address
- req_wdata  in  8  store data
- rsp_valid  out  1  one-cycle result pulse
- rsp_rdata  out  8  load data; 0 for stores
- rsp_err  out  2  0=ok 1=ack_error 2=timeout
- instr_converter_en  out  1  to interface
- instruction  out  updi_instruction  to interface
- size_a, size_b, ptr, size_c  out  2 each  to interface
- cs_addr  out  4  to interface
- sib  out  1  to interface
- data  out  8 x MAX_DATA_SIZE  TX buffer
- data_len  out  DATA_ADDR_BITS+1  bytes following the opcode
- wait_ack_after  out  MAX_DATA_SIZE  ACK mask per data index
- tx_start  out  1  pulse
- tx_ready  in  1  from interface
- rx_n_bytes  out  DATA_ADDR_BITS  bytes to receive
- rx_start  out  1  pulse
- rx_ready, rx_done, rx_timeout, ack_error  in  1 each  from interface
- rx_fifo_data  in  8  output RX FIFO read data
- rx_fifo_empty  in  1  output RX FIFO empty
- rx_fifo_rd_en  out  1  output RX FIFO pop

Behaviour:
- Reset values: all outputs 0, except req_ready=1.
- Buffer registers also reset to 0. Reset mid-transaction returns the FSM to IDLE immediately and issues no rsp.
- Handshake: a request is accepted when req_valid && req_ready. On acceptance all request fields are latched and req_ready drops the next cycle.
- FSM states: IDLE, SETUP, TX_START, TX_WAIT, RX_START, RX_WAIT, POP, RESP.
- IDLE: on accept, go to SETUP.
- SETUP (1 cycle): instr_converter_en=1 and held high through TX_WAIT. Fields per op:
  - LDCS: cs_addr=addr[3:0]; data_len=0; rx_n_bytes=1.
  - STCS: data[0]=wdata; data_len=1; mask=0.
  - LDS: size_a=1 (word address), size_b=0; data[0..1]=addr LSB-first; data_len=2; rx_n_bytes=1.
  - STS: size_a=1, size_b=0; data[0..2]=addrL, addrH, wdata; data_len=3; mask bits 1 and 2 set (ACK after address, ACK after data).
  - Unused fields: ptr=0, sib=0, size_c=0.
- TX_START: wait for tx_ready=1, pulse tx_start for 1 cycle.
  - Stores (masked ACKs): pulse rx_start in the same cycle so the input handler is armed for ACK, with rx_n_bytes=0.
- TX_WAIT: leave when tx_ready returns to 1, at least 1 cycle after tx_start.
  - Loads go to RX_START.
  - Stores go to RX_WAIT if the mask is nonzero, else RESP.
- RX_START: wait for rx_ready, pulse rx_start, go to RX_WAIT.
- RX_WAIT:
  - rx_done: loads go to POP, stores go to RESP ok.
  - ack_error: RESP err=1.
  - rx_timeout: RESP err=2.
  - ack_error and rx_timeout in the same cycle: ack_error wins.
- POP: wait for !rx_fifo_empty, assert rx_fifo_rd_en for 1 cycle, capture rx_fifo_data the same cycle (first-word-fall-through FIFO), go to RESP.
- RESP: rsp_valid=1 for 1 cycle, then IDLE; req_ready=1 the following cycle.
- Watchdog: a counter clears on every state change. If it reaches TIMEOUT_CYCLES-1 in TX_START, TX_WAIT, RX_START, RX_WAIT or POP, go to RESP with err=2.
- rsp_rdata and rsp_err hold their values until the next RESP.

Optional Feature:
- Macro: UPDI_TXN_RETRY_EN.
- Defined: on err=1 or 2, the controller re-enters SETUP up to 2 extra times, with a 3-cycle gap between attempts.
  - rsp_err reports the final attempt's result.
  - Retry count is held in a 2-bit counter, cleared on accept.
- Undefined: no retry; the first error goes straight to RESP.

Decomposition:
- Shared package updi_pkg: updi_instruction enum (existing), a new updi_txn_op_t enum (LDCS/STCS/LDS/STS), updi_txn_err_t (OK/ACK_ERR/TIMEOUT), and the FSM state typedef.
- One sub-module, updi_txn_watchdog: a loadable counter with clear and expire outputs.

Test Plan:
- LDCS cs=0x0: accept, check tx_start with data_len=0, rx_n_bytes=1. FIFO returns 0x30 -> rsp_valid, rdata=0x30, err=0.
- STS addr=0x1234 wdata=0xA5 -> data=34,12,A5; data_len=3; wait_ack_after=0b110. rx_done -> rsp err=0, rdata=0.
- LDS addr=0x0F01 with ack_error asserted in RX_WAIT -> rsp err=1. With retry enabled, 3 tx_start pulses are seen before rsp.
- tx_ready held low after SETUP for TIMEOUT_CYCLES -> rsp err=2, no tx_start issued.
- Assert rst during RX_WAIT -> next cycle all outputs are 0, req_ready=1, no rsp_valid. The following STCS completes normally.
- Back-to-back requests with req_valid held high -> second accept occurs exactly 1 cycle after rsp_valid, with no request lost or duplicated.
